// File: rtl/np_flash_arb.sv
// Two-port arbiter in front of a single-lane SPI flash READ engine (mode 0).
// Sends the 0xAB wake command after reset, then serves 32-bit little-endian reads (0x03).
module np_flash_arb #(
    parameter int CLKDIV   = 1,
    parameter int CSB_GAP  = 2,
    parameter int WAKE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [23:0] req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [23:0] req1_addr,
    output logic        req1_ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0_do,
    input  logic        flash_io1_di
);
    typedef enum logic [2:0] {WAKE, WAKE_WAIT, IDLE, CMD, ADDR, DATA, DONE, GAP} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  div_cnt_reg;
    logic        phase_reg;
    logic [4:0]  bit_cnt_reg;
    logic [15:0] wait_cnt_reg;
    logic [23:0] tx_sr_reg;
    logic [31:0] rx_sr_reg;
    logic [23:0] addr_reg;
    logic        gnt_reg, last_gnt_reg, wake_go_reg;
    logic        csb_reg, sck_reg, io0_reg, ready0_reg, ready1_reg;
    logic [31:0] rdata_reg;

    logic shifting, bit_end, pick, csb_next;

    always_comb begin
        shifting = (state_reg == WAKE && wake_go_reg) || state_reg == CMD ||
                   state_reg == ADDR || state_reg == DATA;
        bit_end  = shifting && phase_reg && (div_cnt_reg == 8'(CLKDIV - 1));
        // On a tie the port that lost last time wins.
        pick     = (req0_valid && req1_valid) ? ~last_gnt_reg : req1_valid;
        // WAKE drives CSB low one cycle after entry, so reset can leave it high.
        csb_next = !(state_next == CMD || state_next == ADDR || state_next == DATA ||
                     state_next == DONE || (state_reg == WAKE && state_next == WAKE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WAKE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAKE:      if (bit_end && bit_cnt_reg == 5'd7) state_next = WAKE_WAIT;
            WAKE_WAIT: if (wait_cnt_reg == 16'(WAKE_CYC - 1)) state_next = IDLE;
            IDLE:      if (req0_valid || req1_valid) state_next = CMD;
            CMD:       if (bit_end && bit_cnt_reg == 5'd7) state_next = ADDR;
            ADDR:      if (bit_end && bit_cnt_reg == 5'd23) state_next = DATA;
            DATA:      if (bit_end && bit_cnt_reg == 5'd31) state_next = DONE;
            DONE:      state_next = GAP;
            GAP:       if (wait_cnt_reg == 16'(CSB_GAP - 1)) state_next = IDLE;
            default:   state_next = WAKE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg  <= 8'd0;
            phase_reg    <= 1'b0;
            bit_cnt_reg  <= 5'd0;
            wait_cnt_reg <= 16'd0;
            tx_sr_reg    <= 24'd0;
            rx_sr_reg    <= 32'd0;
            addr_reg     <= 24'd0;
            gnt_reg      <= 1'b0;
            last_gnt_reg <= 1'b1;
            wake_go_reg  <= 1'b0;
            csb_reg      <= 1'b1;
            sck_reg      <= 1'b0;
            io0_reg      <= 1'b0;
            ready0_reg   <= 1'b0;
            ready1_reg   <= 1'b0;
            rdata_reg    <= 32'd0;
        end else begin
            ready0_reg <= 1'b0;
            ready1_reg <= 1'b0;
            csb_reg    <= csb_next;

            // tx_sr_reg holds the bits still to send after the one on io0, left-aligned.
            if (state_next != state_reg) begin
                div_cnt_reg  <= 8'd0;
                phase_reg    <= 1'b0;
                bit_cnt_reg  <= 5'd0;
                wait_cnt_reg <= 16'd0;
                sck_reg      <= 1'b0;
                io0_reg      <= 1'b0;
                if (state_next == CMD) begin
                    tx_sr_reg <= {7'b0000011, 17'd0};
                end else if (state_next == ADDR) begin
                    io0_reg   <= addr_reg[23];
                    tx_sr_reg <= {addr_reg[22:0], 1'b0};
                end
            end else if (state_reg == WAKE && !wake_go_reg) begin
                wake_go_reg <= 1'b1;
                io0_reg     <= 1'b1;
                tx_sr_reg   <= {7'b0101011, 17'd0};
            end else if (shifting) begin
                if (div_cnt_reg == 8'(CLKDIV - 1)) begin
                    div_cnt_reg <= 8'd0;
                    phase_reg   <= ~phase_reg;
                    sck_reg     <= ~phase_reg;
                    if (phase_reg) begin
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        io0_reg     <= tx_sr_reg[23];
                        tx_sr_reg   <= {tx_sr_reg[22:0], 1'b0};
                    end
                end else begin
                    div_cnt_reg <= div_cnt_reg + 8'd1;
                end
            end else if (state_reg == WAKE_WAIT || state_reg == GAP) begin
                wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end

            if (state_reg == DATA && bit_end) begin
                rx_sr_reg <= {rx_sr_reg[30:0], flash_io1_di};
            end

            if (state_reg == IDLE && state_next == CMD) begin
                gnt_reg      <= pick;
                last_gnt_reg <= pick;
                addr_reg     <= pick ? req1_addr : req0_addr;
            end

            // First received byte sits in the top of rx_sr_reg; it belongs in the low byte.
            if (state_reg == DONE) begin
                rdata_reg  <= {rx_sr_reg[7:0], rx_sr_reg[15:8], rx_sr_reg[23:16], rx_sr_reg[31:24]};
                ready0_reg <= ~gnt_reg;
                ready1_reg <= gnt_reg;
            end
        end
    end

    assign req0_ready   = ready0_reg;
    assign req1_ready   = ready1_reg;
    assign rdata        = rdata_reg;
    assign busy         = (state_reg != IDLE);
    assign flash_csb    = csb_reg;
    assign flash_clk    = sck_reg;
    assign flash_io0_do = io0_reg;
endmodule
